axi_rd_arbiter_rr: RTL
======================

// Module: axi_rd_arbiter_rr
// PURPOSE
//  N-to-1 AXI3 read-channel arbiter between the CPU's read masters (I-fetch, D-load, ...) and the single SoC AXI slave port.
//  Round-robin AR arbitration, registered AR output, master index carried in the upper ARID bits for R routing.
//  Outstanding-burst limit; optional kseg0/kseg1 physical address folding.
// PARAMETERS
//  NUM_M    2  number of upstream read masters (>=2)
//  ID_W     4  upstream ID width per master
//  LEN_W    4  ARLEN width (AXI3)
//  MAX_OUT  4  max AR bursts accepted downstream without their RLAST (>=1)
//  IDX_W    $clog2(NUM_M), localparam; master index width
// PORTS
//  aclk           in   1             clock, all logic on rising edge
//  areset         in   1             synchronous reset, active-high
//  s_axi_arid     in   NUM_M*ID_W    per-master ARID, master i at [i*ID_W +: ID_W]
//  s_axi_araddr   in   NUM_M*32      per-master ARADDR
//  s_axi_arlen    in   NUM_M*LEN_W   per-master ARLEN
//  s_axi_arsize   in   NUM_M*3       per-master ARSIZE
//  s_axi_arvalid  in   NUM_M         per-master ARVALID
//  s_axi_arready  out  NUM_M         per-master ARREADY (one-hot or zero)
//  s_axi_rid      out  ID_W          RID low bits, broadcast
//  s_axi_rdata    out  32            RDATA, broadcast
//  s_axi_rlast    out  1             RLAST, broadcast
//  s_axi_rvalid   out  NUM_M         RVALID, only to the owning master
//  s_axi_rready   in   NUM_M         per-master RREADY
//  m_axi_arid     out  ID_W+IDX_W    {master index, upstream ARID}
//  m_axi_araddr   out  32            ARADDR (folded if ADDR_MAP_EN)
//  m_axi_arlen    out  LEN_W         ARLEN
//  m_axi_arsize   out  3             ARSIZE
//  m_axi_arvalid  out  1             ARVALID, registered
//  m_axi_arready  in   1             ARREADY
//  m_axi_rid      in   ID_W+IDX_W    RID
//  m_axi_rdata    in   32            RDATA
//  m_axi_rlast    in   1             RLAST
//  m_axi_rvalid   in   1             RVALID
//  m_axi_rready   out  1             RREADY
// BEHAVIOUR
//  - Reset: state IDLE, m_axi_arvalid=0, AR regs=0, rr_ptr=0, out_cnt=0; s_axi_arready=0 while areset=1.
//  - FSM IDLE: if out_cnt<MAX_OUT and any s_axi_arvalid, grant g = first requester at or after rr_ptr (mod NUM_M);
//    s_axi_arready[g]=1 that cycle (combinational); capture id/addr/len/size into AR regs; next state HOLD.
//  - FSM HOLD: m_axi_arvalid=1, AR regs stable; on m_axi_arready -> IDLE, rr_ptr<=(g+1)%NUM_M, out_cnt++.
//    No s_axi_arready in HOLD.
//  - Throughput: one AR per 2 cycles minimum; upstream AR-to-downstream ARVALID latency 1 cycle.
//  - out_cnt width $clog2(MAX_OUT+1); decrement on m_axi_rvalid&m_axi_rready&m_axi_rlast.
//    Inc and dec in the same cycle -> unchanged. out_cnt==MAX_OUT blocks grants, never wraps.
//  - R routing, combinational: k = m_axi_rid[ID_W+:IDX_W].
//    s_axi_rvalid[k]=m_axi_rvalid, others 0; m_axi_rready=s_axi_rready[k]; s_axi_rid=m_axi_rid[ID_W-1:0].
//  - k>=NUM_M (non-power-of-2 NUM_M): all s_axi_rvalid=0, m_axi_rready=1, beat dropped (still counts RLAST).
//  - Reset mid-burst: FSM/counters cleared immediately; downstream responses arriving later still routed by RID,
//    RLAST decrement saturates at 0.
// CONFIGURATION
//  AXI_RD_ADDR_MAP_EN defined: at capture, addr[31:29] of 3'b100 or 3'b101 replaced by 3'b000 (kseg0/kseg1 -> phys).
//  Not defined: araddr passed unmodified.
// TESTING
//  - Reset 3 cycles with arvalid=2'b11 -> arready=0, m_arvalid=0 throughout; first cycle after reset arready=2'b01.
//  - Both masters valid continuously, arready=1 -> grants 0,1,0,1; m_arid[4]=0,1,0,1.
//  - MAX_OUT=2, no R beats -> after 2 AR handshakes arready stays 0; one RLAST beat -> next grant 1 cycle later.
//  - R beat rid=5'h13, rready=2'b10 -> s_rvalid=2'b10, s_rid=4'h3, m_rready=1; rready=2'b00 -> m_rready=0.
//  - ADDR_MAP_EN: araddr=0xBFC00000 -> m_araddr=0x1FC00000; 0x9FC00010 -> 0x1FC00010; 0x1FC00000 unchanged.
//  - AR handshake and RLAST in same cycle with out_cnt=1 -> out_cnt stays 1.

Source files
------------

// File: rtl/axi_rd_arbiter_rr.sv
// ============================================================================
// axi_rd_arbiter_rr
// ----------------------------------------------------------------------------
// N-to-1 AXI3 read-channel arbiter. It sits between the CPU's read masters
// (I-fetch, D-load, ...) and the single SoC AXI slave port.
//
//  - AR channel: round-robin arbitration among the upstream masters. The
//    winner's id/addr/len/size are captured into registers and presented
//    downstream on the following cycle. The master index is prepended to
//    ARID so that read data can be routed back.
//  - R channel: purely combinational routing. The upper RID bits select the
//    owning master; only that master sees RVALID, and its RREADY is returned.
//  - Outstanding limit: at most MAX_OUT bursts may be accepted downstream
//    whose RLAST has not yet been seen. Further grants are held off.
//
// Optional feature (compile-time macro AXI_RD_ADDR_MAP_EN):
//  When defined, kseg0/kseg1 virtual addresses (addr[31:29] = 3'b100 or
//  3'b101) are folded to physical space (addr[31:29] = 3'b000) at capture.
//  When undefined, ARADDR is passed through unmodified.
//
// Ports:
//  aclk, areset       clock (rising edge) and synchronous active-high reset
//  s_axi_ar*          per-master AR channels, master i at slice i
//  s_axi_arready      one-hot (or zero) AR grant back to the masters
//  s_axi_r*           broadcast RID low bits / RDATA / RLAST, per-master RVALID,
//                     per-master RREADY in
//  m_axi_ar*          registered downstream AR channel, ARID = {index, id}
//  m_axi_r*           downstream R channel, RREADY from the owning master
// ============================================================================
module axi_rd_arbiter_rr #(
    parameter  int NUM_M   = 2,
    parameter  int ID_W    = 4,
    parameter  int LEN_W   = 4,
    parameter  int MAX_OUT = 4,
    localparam int IDX_W   = $clog2(NUM_M)
) (
    input  logic                     aclk,
    input  logic                     areset,

    input  logic [NUM_M*ID_W-1:0]    s_axi_arid,
    input  logic [NUM_M*32-1:0]      s_axi_araddr,
    input  logic [NUM_M*LEN_W-1:0]   s_axi_arlen,
    input  logic [NUM_M*3-1:0]       s_axi_arsize,
    input  logic [NUM_M-1:0]         s_axi_arvalid,
    output logic [NUM_M-1:0]         s_axi_arready,

    output logic [ID_W-1:0]          s_axi_rid,
    output logic [31:0]              s_axi_rdata,
    output logic                     s_axi_rlast,
    output logic [NUM_M-1:0]         s_axi_rvalid,
    input  logic [NUM_M-1:0]         s_axi_rready,

    output logic [ID_W+IDX_W-1:0]    m_axi_arid,
    output logic [31:0]              m_axi_araddr,
    output logic [LEN_W-1:0]         m_axi_arlen,
    output logic [2:0]               m_axi_arsize,
    output logic                     m_axi_arvalid,
    input  logic                     m_axi_arready,

    input  logic [ID_W+IDX_W-1:0]    m_axi_rid,
    input  logic [31:0]              m_axi_rdata,
    input  logic                     m_axi_rlast,
    input  logic                     m_axi_rvalid,
    output logic                     m_axi_rready
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       grant_sel;
    logic                   grant_found;
    logic [IDX_W:0]         cand_sum;

    logic                   ar_fire;
    logic                   ar_done;
    logic                   rlast_beat;

    logic [CNT_W-1:0]       out_cnt;

    logic [ID_W+IDX_W-1:0]  ar_id;
    logic [31:0]            ar_addr;
    logic [LEN_W-1:0]       ar_len;
    logic [2:0]             ar_size;

    logic [ID_W-1:0]        sel_id;
    logic [31:0]            sel_addr;
    logic [LEN_W-1:0]       sel_len;
    logic [2:0]             sel_size;

    logic [IDX_W-1:0]       rt_idx;

    // Physical address folding applied at capture time.
    function automatic logic [31:0] fold_addr(input logic [31:0] a);
`ifdef AXI_RD_ADDR_MAP_EN
        if (a[31:29] == 3'b100 || a[31:29] == 3'b101) begin
            fold_addr = {3'b000, a[28:0]};
        end else begin
            fold_addr = a;
        end
`else
        fold_addr = a;
`endif
    endfunction

    // Round-robin search: the first requesting master at or after rr_ptr,
    // wrapping modulo NUM_M. The candidate index is formed one bit wider so
    // the wrap is a single conditional subtract, valid for any NUM_M.
    always_comb begin
        grant_found = 1'b0;
        grant_sel   = '0;
        cand_sum    = '0;
        for (int i = 0; i < NUM_M; i++) begin
            cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand_sum >= (IDX_W+1)'(NUM_M)) begin
                cand_sum = cand_sum - (IDX_W+1)'(NUM_M);
            end
            if (!grant_found && s_axi_arvalid[cand_sum[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_sel   = cand_sum[IDX_W-1:0];
            end
        end
    end

    // Select the winning master's AR fields from the packed input buses.
    always_comb begin
        sel_id   = '0;
        sel_addr = '0;
        sel_len  = '0;
        sel_size = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_sel == IDX_W'(i)) begin
                sel_id   = s_axi_arid[i*ID_W +: ID_W];
                sel_addr = s_axi_araddr[i*32 +: 32];
                sel_len  = s_axi_arlen[i*LEN_W +: LEN_W];
                sel_size = s_axi_arsize[i*3 +: 3];
            end
        end
    end

    // FSM next-state and handshake decode. Grants are only issued from IDLE,
    // never while reset is asserted, and never once the outstanding limit
    // is reached; HOLD simply waits for the downstream ARREADY.
    always_comb begin
        state_nxt     = state;
        s_axi_arready = '0;
        ar_fire       = 1'b0;
        ar_done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!areset && grant_found && (out_cnt < CNT_W'(MAX_OUT))) begin
                    ar_fire                  = 1'b1;
                    s_axi_arready[grant_sel] = 1'b1;
                    state_nxt                = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (m_axi_arready) begin
                    ar_done   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // AR capture registers and round-robin pointer. The pointer advances past
    // the granted master only once its request has actually left downstream.
    always_ff @(posedge aclk) begin
        if (areset) begin
            ar_id     <= '0;
            ar_addr   <= '0;
            ar_len    <= '0;
            ar_size   <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            if (ar_fire) begin
                ar_id     <= {grant_sel, sel_id};
                ar_addr   <= fold_addr(sel_addr);
                ar_len    <= sel_len;
                ar_size   <= sel_size;
                grant_idx <= grant_sel;
            end
            if (ar_done) begin
                rr_ptr <= (grant_idx == IDX_W'(NUM_M - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    assign rlast_beat = m_axi_rvalid & m_axi_rready & m_axi_rlast;

    // Outstanding-burst counter. A simultaneous accept and RLAST cancel out.
    // The decrement saturates at zero, which matters when responses for
    // bursts issued before a reset trickle in afterwards.
    always_ff @(posedge aclk) begin
        if (areset) begin
            out_cnt <= '0;
        end else if (ar_done && !rlast_beat) begin
            if (out_cnt != CNT_W'(MAX_OUT)) begin
                out_cnt <= out_cnt + 1'b1;
            end
        end else if (!ar_done && rlast_beat) begin
            if (out_cnt != '0) begin
                out_cnt <= out_cnt - 1'b1;
            end
        end
    end

    assign m_axi_arvalid = (state == ST_HOLD);
    assign m_axi_arid    = ar_id;
    assign m_axi_araddr  = ar_addr;
    assign m_axi_arlen   = ar_len;
    assign m_axi_arsize  = ar_size;

    // R routing by the master index in the upper RID bits. An index with no
    // matching master (possible when NUM_M is not a power of two) is drained
    // with RREADY forced high so the downstream slave cannot stall.
    assign rt_idx = m_axi_rid[ID_W +: IDX_W];

    always_comb begin
        s_axi_rvalid = '0;
        m_axi_rready = 1'b1;
        for (int i = 0; i < NUM_M; i++) begin
            if (rt_idx == IDX_W'(i)) begin
                s_axi_rvalid[i] = m_axi_rvalid;
                m_axi_rready    = s_axi_rready[i];
            end
        end
    end

    assign s_axi_rid   = m_axi_rid[ID_W-1:0];
    assign s_axi_rdata = m_axi_rdata;
    assign s_axi_rlast = m_axi_rlast;

endmodule
